// File: rtl/dmem_hs.sv
// Handshaked data memory: one outstanding request, WAIT_CYCLES wait states,
// registered load data and access-fault reporting.
package dmem_pkg;
  localparam int XLEN      = 32;
  localparam int DMEM_SIZE = 1024;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_e;
endpackage

module dmem_hs
  import dmem_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned     DEPTH_BYTES = DMEM_SIZE,
  parameter int unsigned     WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  mem_op_e         req_op,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int              AW        = $clog2(DEPTH_BYTES);
  localparam int              NWORDS    = DEPTH_BYTES / 4;
  localparam int              IW        = (AW > 2) ? AW - 2 : 1;
  localparam logic [XLEN-1:0] DEPTH_L   = XLEN'(DEPTH_BYTES);
  localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  mem_op_e         op_q, op_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;

  logic [XLEN-1:0] mem_q [NWORDS];

  logic            enter_resp;
  logic            cur_we;
  logic [XLEN-1:0] cur_addr, cur_wdata, offset, word, shifted, rd_ext;
  mem_op_e         cur_op;
  logic [IW-1:0]   idx;
  logic [1:0]      lane;
  logic [15:0]     half_v;
  logic            fault;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_we;

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // With zero wait states the response is built on the accept edge, so the
  // live request is decoded in IDLE and the latched copy everywhere else.
  always_comb begin
    cur_we    = (state_q == S_IDLE) ? req_we    : we_q;
    cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    cur_op    = (state_q == S_IDLE) ? req_op    : op_q;

    offset  = cur_addr - BASE_ADDR;
    idx     = IW'(offset >> 2);
    lane    = offset[1:0];
    word    = mem_q[idx];
    shifted = word >> {lane, 3'b000};
    half_v  = lane[1] ? word[31:16] : word[15:0];

    fault     = (offset >= DEPTH_L);
    rd_ext    = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (cur_op)
      MEM_BYTE: begin
        rd_ext    = {{24{shifted[7]}}, shifted[7:0]};
        mem_be    = 4'b0001 << lane;
        mem_wdata = {4{cur_wdata[7:0]}};
      end
      MEM_BYTE_U: begin
        rd_ext = {24'd0, shifted[7:0]};
        if (cur_we) fault = 1'b1;
      end
      MEM_HALF: begin
        rd_ext    = {{16{half_v[15]}}, half_v};
        mem_be    = lane[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{cur_wdata[15:0]}};
        if (lane[0]) fault = 1'b1;
      end
      MEM_HALF_U: begin
        rd_ext = {16'd0, half_v};
        if (lane[0] || cur_we) fault = 1'b1;
      end
      MEM_WORD: begin
        rd_ext    = word;
        mem_be    = 4'b1111;
        mem_wdata = cur_wdata;
        if (lane != 2'd0) fault = 1'b1;
      end
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    enter_resp   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          op_d    = req_op;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) enter_resp = 1'b1;
        else               cnt_d      = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      state_d      = S_RESP;
      resp_valid_d = 1'b1;
      resp_err_d   = fault;
      resp_rdata_d = (fault || cur_we) ? '0 : rd_ext;
    end
  end

  assign mem_we = enter_resp && cur_we && !fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= MEM_BYTE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: four instances covering wait-state counts 1, 0, 15 and 3,
// a vector table plus hand-written back-pressure and reset-abort sequences.
module tb_dmem_hs;
  import dmem_pkg::*;

  localparam int N = 4;
  localparam logic [31:0] BA [N] = '{32'h0, 32'h1000, 32'h0, 32'h0};
  localparam int unsigned DB [N] = '{1024, 256, 1024, 1024};
  localparam int unsigned WC [N] = '{1, 0, 15, 3};

  logic        clk = 1'b0;
  logic        reset      [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  mem_op_e     req_op     [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_hs #(
      .BASE_ADDR(BA[g]), .DEPTH_BYTES(DB[g]), .WAIT_CYCLES(WC[g])
    ) u_dut (
      .clk(clk), .reset(reset[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_op(req_op[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
    );
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb [$];
  vec_t tbl [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] op, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.op = op; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Present a request and return just after the accept edge, with the
  // request inputs scrambled so only the latched copy can be used.
  task automatic drive_req(input int k, input vec_t v, input string name);
    int t;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = v.we;
    req_addr[k]  = v.addr;
    req_wdata[k] = v.wdata;
    req_op[k]    = mem_op_e'(v.op);
    t = 0;
    while (!req_ready[k] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[k]) chk({name, " accept timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_we[k]    = ~v.we;
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_op[k]    = mem_op_e'(3'($urandom_range(0, 7)));
  endtask

  task automatic collect(input int k, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[k] && lat < 40);
    if (sb.size() == 0) begin
      chk("scoreboard underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.name, " latency"}, 32'(lat), 32'(e.lat));
    chk({e.name, " rdata"}, resp_rdata[k], e.rdata);
    chk({e.name, " err"}, {31'd0, resp_err[k]}, {31'd0, e.err});
    chk({e.name, " req_ready in RESP"}, {31'd0, req_ready[k]}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({e.name, " held valid"}, {31'd0, resp_valid[k]}, 32'd1);
      chk({e.name, " held rdata"}, resp_rdata[k], e.rdata);
      chk({e.name, " held err"}, {31'd0, resp_err[k]}, {31'd0, e.err});
      chk({e.name, " held req_ready"}, {31'd0, req_ready[k]}, 32'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    @(negedge clk);
    chk({e.name, " req_ready after handshake"}, {31'd0, req_ready[k]}, 32'd1);
    chk({e.name, " resp_valid after handshake"}, {31'd0, resp_valid[k]}, 32'd0);
  endtask

  task automatic txn(input int k, input vec_t v, input string name, input int hold);
    exp_t e;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.lat   = int'(WC[k]) + 1;
    e.name  = name;
    sb.push_back(e);
    drive_req(k, v, name);
    collect(k, hold);
  endtask

  task automatic check_cleared(input int k, input string name, input logic rdy);
    chk({name, " req_ready"}, {31'd0, req_ready[k]}, {31'd0, rdy});
    chk({name, " resp_valid"}, {31'd0, resp_valid[k]}, 32'd0);
    chk({name, " resp_rdata"}, resp_rdata[k], 32'd0);
    chk({name, " resp_err"}, {31'd0, resp_err[k]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      reset[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_op[k] = MEM_WORD; resp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) check_cleared(k, $sformatf("reset%0d", k), 1'b0);
    for (int k = 0; k < N; k++) reset[k] = 1'b0;
    #1;
    for (int k = 0; k < N; k++) check_cleared(k, $sformatf("post_reset%0d", k), 1'b1);

    tbl.push_back(mk(1, 32'h10,  32'hDEADBEEF, MEM_WORD,   32'h0,        0));
    tbl.push_back(mk(0, 32'h10,  32'h0,        MEM_WORD,   32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 32'h13,  32'h0,        MEM_BYTE,   32'hFFFFFFDE, 0));
    tbl.push_back(mk(0, 32'h11,  32'h0,        MEM_BYTE_U, 32'h000000BE, 0));
    tbl.push_back(mk(0, 32'h12,  32'h0,        MEM_HALF,   32'hFFFFDEAD, 0));
    tbl.push_back(mk(0, 32'h10,  32'h0,        MEM_HALF_U, 32'h0000BEEF, 0));
    tbl.push_back(mk(1, 32'h11,  32'h000000AA, MEM_BYTE,   32'h0,        0));
    tbl.push_back(mk(0, 32'h10,  32'h0,        MEM_WORD,   32'hDEADAAEF, 0));
    tbl.push_back(mk(0, 32'h12,  32'h0,        MEM_WORD,   32'h0,        1));
    tbl.push_back(mk(1, 32'h11,  32'h00005555, MEM_HALF,   32'h0,        1));
    tbl.push_back(mk(0, 32'h10,  32'h0,        MEM_WORD,   32'hDEADAAEF, 0));
    tbl.push_back(mk(1, 32'h14,  32'h00000077, MEM_BYTE_U, 32'h0,        1));
    tbl.push_back(mk(0, 32'h400, 32'h0,        MEM_WORD,   32'h0,        1));
    tbl.push_back(mk(1, 32'h14,  32'h11223344, MEM_WORD,   32'h0,        0));
    tbl.push_back(mk(1, 32'h16,  32'h1234CAFE, MEM_HALF,   32'h0,        0));
    tbl.push_back(mk(0, 32'h14,  32'h0,        MEM_WORD,   32'hCAFE3344, 0));
    tbl.push_back(mk(0, 32'h16,  32'h0,        MEM_HALF,   32'hFFFFCAFE, 0));
    tbl.push_back(mk(0, 32'h10,  32'h0,        MEM_BYTE,   32'hFFFFFFEF, 0));
    tbl.push_back(mk(0, 32'h10,  32'h0,        3'd3,       32'h0,        1));
    tbl.push_back(mk(1, 32'h14,  32'hFFFFFFFF, 3'd7,       32'h0,        1));
    tbl.push_back(mk(1, 32'h14,  32'h0000FFFF, MEM_HALF_U, 32'h0,        1));
    tbl.push_back(mk(0, 32'h14,  32'h0,        MEM_WORD,   32'hCAFE3344, 0));
    tbl.push_back(mk(1, 32'h3FC, 32'h80000001, MEM_WORD,   32'h0,        0));
    tbl.push_back(mk(0, 32'h3FF, 32'h0,        MEM_BYTE_U, 32'h00000080, 0));
    tbl.push_back(mk(0, 32'h3FE, 32'h0,        MEM_HALF,   32'hFFFF8000, 0));
    for (int i = 0; i < tbl.size(); i++) txn(0, tbl[i], $sformatf("vec%0d", i), 0);

    txn(0, mk(0, 32'h10, 32'h0, MEM_WORD, 32'hDEADAAEF, 0), "bp_load", 5);
    txn(0, mk(0, 32'h12, 32'h0, MEM_WORD, 32'h0, 1), "bp_err", 5);

    // Zero wait states, non-zero base: below-base wraps to out of range.
    txn(1, mk(1, 32'h1000, 32'hCAFEF00D, MEM_WORD,   32'h0,        0), "w0_store", 0);
    txn(1, mk(0, 32'h1000, 32'h0,        MEM_WORD,   32'hCAFEF00D, 0), "w0_load", 0);
    txn(1, mk(0, 32'h0FFC, 32'h0,        MEM_WORD,   32'h0,        1), "w0_below", 0);
    txn(1, mk(0, 32'h1100, 32'h0,        MEM_WORD,   32'h0,        1), "w0_above", 0);
    txn(1, mk(1, 32'h10FC, 32'h01020304, MEM_WORD,   32'h0,        0), "w0_top_store", 0);
    txn(1, mk(0, 32'h10FF, 32'h0,        MEM_BYTE_U, 32'h00000001, 0), "w0_top_byte", 0);
    txn(1, mk(0, 32'h10FE, 32'h0,        MEM_HALF,   32'h00000102, 0), "w0_top_half", 0);

    txn(2, mk(1, 32'h40, 32'h55AA33CC, MEM_WORD,   32'h0,        0), "w15_store", 0);
    txn(2, mk(0, 32'h42, 32'h0,        MEM_HALF_U, 32'h000055AA, 0), "w15_load", 0);

    // Abort while the store is still waiting: memory must keep the old word.
    txn(3, mk(1, 32'h20, 32'h0, MEM_WORD, 32'h0, 0), "w3_clear", 0);
    drive_req(3, mk(1, 32'h20, 32'h12345678, MEM_WORD, 32'h0, 0), "w3_abort_wait");
    @(posedge clk);
    #2;
    reset[3] = 1'b1;
    #1;
    check_cleared(3, "abort_wait", 1'b0);
    repeat (2) @(negedge clk);
    reset[3] = 1'b0;
    txn(3, mk(0, 32'h20, 32'h0, MEM_WORD, 32'h0, 0), "w3_after_abort_wait", 0);

    // Abort once in RESP: the store has already committed.
    drive_req(3, mk(1, 32'h24, 32'hA5A5A5A5, MEM_WORD, 32'h0, 0), "w3_abort_resp");
    repeat (4) @(negedge clk);
    chk("abort_resp reached RESP", {31'd0, resp_valid[3]}, 32'd1);
    reset[3] = 1'b1;
    #1;
    check_cleared(3, "abort_resp", 1'b0);
    repeat (2) @(negedge clk);
    reset[3] = 1'b0;
    txn(3, mk(0, 32'h24, 32'h0, MEM_WORD, 32'hA5A5A5A5, 0), "w3_after_abort_resp", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_hs.md
# dmem_hs

Handshaked, parametrised data memory for the backend memory stage. It replaces the single-cycle combinational-read data memory with a request/response interface, a configurable number of wait states, and registered read data. It also reports errors for misaligned, out-of-range and illegal accesses. One request is outstanding at a time, and the memory stage stalls on `req_ready`/`resp_valid`.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: first byte address decoded by this block.
- `DEPTH_BYTES`, default `DMEM_SIZE`: byte capacity. Must be a power of two and ≥ 4.
- `WAIT_CYCLES`, default 1: extra cycles before the response. Legal range 0..15.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `req_op` in `mem_op_e`: `MEM_BYTE`, `MEM_HALF`, `MEM_WORD`, `MEM_BYTE_U` or `MEM_HALF_U`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out XLEN: load result, extended per `req_op`. 0 for stores and errors.
- `resp_err` out 1: access faulted. No memory side effect occurred.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:** `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_we`, address, wdata and op.
  - Go to RESP if `WAIT_CYCLES`=0. Otherwise go to WAIT with the counter loaded to `WAIT_CYCLES`-1.
- **WAIT:** decrement the counter each cycle. Go to RESP on the edge where the counter is 0.
- **Entering RESP** (single edge): evaluate the error condition, perform the store or register the load data, and set `resp_valid`=1.
- **RESP:** hold `resp_valid`, `resp_rdata` and `resp_err` stable until `resp_valid`&&`resp_ready`. Then go to IDLE.
- **Offset and decode:** offset = `req_addr` − `BASE_ADDR`, compared unsigned. Word index = offset[..:2]; byte lane = offset[1:0].
- **Error conditions** (any one sets `resp_err`=1, suppresses the write, and forces `resp_rdata`=0):
  - offset ≥ `DEPTH_BYTES`, which includes addresses below `BASE_ADDR` via unsigned wrap;
  - `MEM_HALF`/`MEM_HALF_U` with offset[0]=1;
  - `MEM_WORD` with offset[1:0]≠0;
  - store with `MEM_BYTE_U` or `MEM_HALF_U`;
  - any `req_op` encoding outside the five listed.
- **Loads:** little-endian.
  - `MEM_BYTE` / `MEM_BYTE_U`: byte at the lane, sign- or zero-extended to 32 bits.
  - `MEM_HALF` / `MEM_HALF_U`: halfword at lane 0 or 2, sign- or zero-extended.
  - `MEM_WORD`: the full word.
- **Stores:**
  - `MEM_BYTE` writes `wdata[7:0]` to the addressed byte.
  - `MEM_HALF` writes `wdata[15:0]` to bytes lane and lane+1.
  - `MEM_WORD` writes all 4 bytes.
  - No other bytes change.
- **Storage:** word-organised array with a per-byte write enable. Memory contents are not reset.

## Timing
- **Reset values:** `req_ready`=0 while `reset` is asserted, and 1 in the first cycle after deassertion (IDLE). `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0, state=IDLE.
- **Latency:** accept edge E0 → `resp_valid` high in cycle E0+1+`WAIT_CYCLES`. Loads, stores and errors all have the same latency.
- **Throughput:** at most one request per 2+`WAIT_CYCLES` cycles. The RESP→IDLE edge is the response handshake, and `req_ready` rises the cycle after it.
- **Back-pressure:** `resp_ready`=0 in RESP holds the state indefinitely, and outputs do not change.
- `req_*` inputs are ignored outside IDLE. The latched copy is used for the whole transaction.
- The store commits at the edge entering RESP, so a load accepted afterwards observes the new data.
- **Reset mid-transaction** (WAIT or RESP): abort to IDLE and clear the outputs.
  - A store still in WAIT is never written.
  - A store already in RESP has been written and remains written.
- `WAIT_CYCLES`=0 skips WAIT entirely, and the counter is then unused.

## Test plan
- **Word round-trip:** `WAIT_CYCLES`=1, `BASE_ADDR`=0. Store `MEM_WORD` 32'hDEADBEEF at 0x10, then load `MEM_WORD` at 0x10. Each `resp_valid` appears 2 cycles after accept; the load gives `resp_rdata`=32'hDEADBEEF, `resp_err`=0.
- **Byte and half extension** (memory at 0x10 = 32'hDEADBEEF):
  - `MEM_BYTE` at 0x13 → 32'hFFFFFFDE;
  - `MEM_BYTE_U` at 0x11 → 32'h000000BE;
  - `MEM_HALF` at 0x12 → 32'hFFFFDEAD;
  - `MEM_HALF_U` at 0x10 → 32'h0000BEEF;
  - then store `MEM_BYTE` 0xAA at 0x11 and load `MEM_WORD` at 0x10 → 32'hDEADAAEF.
- **Errors:**
  - `MEM_WORD` at 0x12 → `resp_err`=1, rdata 0;
  - store `MEM_HALF` at 0x11 → `resp_err`=1, and a later word load at 0x10 is unchanged;
  - store `MEM_BYTE_U` → `resp_err`=1;
  - address `BASE_ADDR`+`DEPTH_BYTES` → `resp_err`=1.
- **Back-pressure:** hold `resp_ready`=0 for 5 cycles in RESP → `resp_valid`, `resp_rdata` and `resp_err` stay constant and `req_ready`=0. Release → handshake, then `req_ready`=1 the next cycle.
- **Latency sweep:** `WAIT_CYCLES`=0 → response 1 cycle after accept. `WAIT_CYCLES`=15 → response 16 cycles after accept.
- **Reset abort:** with `WAIT_CYCLES`=3, assert `reset` asynchronously 1 cycle after accepting a word store of 32'h12345678 to 0x20 (word at 0x20 previously 0) → all outputs 0 immediately. After release, a load at 0x20 returns 0.
